// File: rtl/jtag_host.sv
// jtag_host: host-side IEEE 1149.1 driver. Accepts one scan command at a time
// and walks the target TAP through reset, IR scan, DR scan or idle sequences,
// collecting TDO into a parallel result word.
//
// Optional build macro: JTAG_HOST_TDO_RETIME_EN
//   When defined, TDO bit i is taken one TCK rising edge after shift edge i,
//   for targets whose TDO passes through an extra TCK-clocked output flop.
//
// Parameters:
//   DR_MAX  maximum DR scan length in bits (width of din/dout)
//   IR_LEN  target instruction register length in bits
//
// Ports:
//   TCK     single clock, shared with the target
//   TRST    asynchronous active-high reset (aborts any command)
//   start   command strobe, sampled on TCK rising edge while not busy
//   op      00 TAP reset, 01 IR scan, 10 DR scan, 11 idle cycles
//   len     DR scan length / idle count (clamped to DR_MAX)
//   din     TDI data, shifted LSB first
//   busy    command in progress
//   done    one-cycle completion pulse
//   dout    captured TDO, LSB = first bit out
//   TMS     to target TMS (launched on TCK falling edge)
//   TDI     to target TDI (launched on TCK falling edge)
//   TDO_in  from target TDO
module jtag_host #(
    parameter int DR_MAX = 64,
    parameter int IR_LEN = 2
) (
    input  logic              TCK,
    input  logic              TRST,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [6:0]        len,
    input  logic [DR_MAX-1:0] din,
    output logic              busy,
    output logic              done,
    output logic [DR_MAX-1:0] dout,
    output logic              TMS,
    output logic              TDI,
    input  logic              TDO_in
);

    localparam int MAXN = (DR_MAX > IR_LEN) ? DR_MAX : IR_LEN;
    localparam int CWN  = $clog2(MAXN + 8);
    localparam int CW   = (CWN > 8) ? CWN : 8;

    localparam logic [CW-1:0] DR_MAX_C = CW'(DR_MAX);
    localparam logic [CW-1:0] IR_LEN_C = CW'(IR_LEN);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PRE   = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_POST  = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_RST   = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    // Pre-shift TMS patterns, bit k = TMS on target edge k+1.
    localparam logic [4:0] PAT_IR  = 5'b00011; // 1,1,0,0 -> Shift-IR
    localparam logic [4:0] PAT_DR  = 5'b00001; // 1,0,0   -> Shift-DR
    localparam logic [4:0] PAT_DR0 = 5'b01101; // 1,0,1,1,0 -> Capture, Exit1, Update, Idle

    logic [2:0]        state;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     wait_n;
    logic [CW-1:0]     shift_last;
    logic [2:0]        pre_last;
    logic [4:0]        pre_pat;
    logic              has_shift;
    logic [DR_MAX-1:0] data_q;

    logic              tms_q;
    logic              tdi_q;
    logic              tms_nxt;
    logic              tdi_nxt;

    logic [CW-1:0]     len_ext;
    logic [CW-1:0]     len_c;
    logic              can_accept;
    logic [DR_MAX-1:0] samp_mask;

`ifdef JTAG_HOST_TDO_RETIME_EN
    logic [DR_MAX-1:0] rt_mask;
`endif

    assign len_ext    = CW'(len);
    assign len_c      = (len_ext > DR_MAX_C) ? DR_MAX_C : len_ext;
    assign can_accept = (state == ST_IDLE) || (state == ST_DONE);

    // One-hot position of the bit being shifted on the coming target edge.
    assign samp_mask = (state == ST_SHIFT) ? (DR_MAX'(1) << cnt) : '0;

    // Value to launch on the next falling edge, i.e. what the target sees on
    // its next rising edge. Outside a command the last TMS level is held so
    // the target stays parked wherever the previous command left it.
    always_comb begin
        tms_nxt = tms_q;
        tdi_nxt = 1'b0;
        case (state)
            ST_RST:   tms_nxt = (cnt != CW'(5));
            ST_PRE:   tms_nxt = pre_pat[cnt[2:0]];
            ST_SHIFT: begin
                tms_nxt = (cnt == shift_last);
                tdi_nxt = data_q[0];
            end
            ST_POST:  tms_nxt = (cnt == '0);
            // A zero-length idle command spends its single cycle without
            // disturbing the target, so TMS keeps its current level.
            ST_WAIT:  tms_nxt = (wait_n == '0) ? tms_q : 1'b0;
            default:  tms_nxt = tms_q;
        endcase
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            wait_n     <= '0;
            shift_last <= '0;
            pre_last   <= '0;
            pre_pat    <= '0;
            has_shift  <= 1'b0;
            data_q     <= '0;
            dout       <= '0;
`ifdef JTAG_HOST_TDO_RETIME_EN
            rt_mask    <= '0;
`endif
        end else begin
            // TDO capture; dout is cleared on acceptance, so OR-in is enough.
`ifdef JTAG_HOST_TDO_RETIME_EN
            dout    <= dout | (rt_mask & {DR_MAX{TDO_in}});
            rt_mask <= samp_mask;
`else
            dout    <= dout | (samp_mask & {DR_MAX{TDO_in}});
`endif
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        cnt    <= '0;
                        data_q <= din;
                        dout   <= '0;
                        wait_n <= len_c;
                        case (op)
                            2'b00: state <= ST_RST;
                            2'b01: begin
                                state      <= ST_PRE;
                                pre_pat    <= PAT_IR;
                                pre_last   <= 3'd3;
                                shift_last <= IR_LEN_C - CW'(1);
                                has_shift  <= 1'b1;
                            end
                            2'b10: begin
                                state <= ST_PRE;
                                if (len_c != '0) begin
                                    pre_pat    <= PAT_DR;
                                    pre_last   <= 3'd2;
                                    shift_last <= len_c - CW'(1);
                                    has_shift  <= 1'b1;
                                end else begin
                                    pre_pat    <= PAT_DR0;
                                    pre_last   <= 3'd4;
                                    shift_last <= '0;
                                    has_shift  <= 1'b0;
                                end
                            end
                            default: state <= ST_WAIT;
                        endcase
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RST: begin
                    if (cnt == CW'(5)) state <= ST_DONE;
                    else cnt <= cnt + CW'(1);
                end
                ST_PRE: begin
                    if (cnt[2:0] == pre_last) begin
                        cnt   <= '0;
                        state <= has_shift ? ST_SHIFT : ST_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_SHIFT: begin
                    data_q <= data_q >> 1;
                    if (cnt == shift_last) begin
                        cnt   <= '0;
                        state <= ST_POST;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_POST: begin
                    if (cnt == CW'(1)) state <= ST_DONE;
                    else cnt <= cnt + CW'(1);
                end
                ST_WAIT: begin
                    if ((wait_n == '0) || (cnt == wait_n - CW'(1))) state <= ST_DONE;
                    else cnt <= cnt + CW'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Falling-edge launch: target samples half a cycle later, no hold race.
    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST) begin
            tms_q <= 1'b1;
            tdi_q <= 1'b0;
        end else begin
            tms_q <= tms_nxt;
            tdi_q <= tdi_nxt;
        end
    end

    assign TMS  = tms_q;
    assign TDI  = tdi_q;
    assign busy = !can_accept;
    assign done = (state == ST_DONE);

endmodule

// File: doc/jtag_host.md
# jtag_host

Host-side JTAG driver: the initiator that exercises the team's on-chip TAP controller and its BSR, internal-scan and bypass data registers. It accepts a single scan command from a local controller. It then generates the TMS/TDI sequence that walks the target TAP through the standard IEEE 1149.1 state graph, and collects TDO into a parallel result word. The block sits in test benches and in the bring-up harness, driving the `top` TMS/TDI pins from the same TCK that clocks the target.

## Interface
Parameters:
- `DR_MAX`, default 64: maximum DR scan length in bits; width of `din`/`dout`.
- `IR_LEN`, default 2: target instruction register length in bits.

Ports:
- `TCK`, in, 1: the single clock, shared with the target.
- `TRST`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: command strobe, sampled on the TCK rising edge.
- `op`, in, 2: command code.
  - 00 = TAP reset.
  - 01 = IR scan.
  - 10 = DR scan.
  - 11 = idle cycles.
- `len`, in, 7: DR scan length (op 10) or idle count (op 11); ignored for ops 00 and 01.
- `din`, in, DR_MAX: TDI data, shifted LSB first. IR scans use `din[IR_LEN-1:0]`.
- `busy`, out, 1: command in progress.
- `done`, out, 1: one-cycle completion pulse.
- `dout`, out, DR_MAX: captured TDO, LSB = first bit out. Unused upper bits are 0.
- `TMS`, out, 1: to target TMS.
- `TDI`, out, 1: to target TDI.
- `TDO_in`, in, 1: from target TDO.

## Operation
Reset values: `TMS`=1, `TDI`=0, `busy`=0, `done`=0, `dout`=0, FSM in IDLE.

FSM states: IDLE, PRE, SHIFT, POST, WAIT, RST, DONE.
- In IDLE, `start`=1 latches `op`, `len` and `din`, clears `dout`, sets `busy`, and moves to the op-specific state.
- `start` while `busy`=1 is ignored. The latched operands are unaffected.

Target-edge sequences. Edge 1 is the first target rising edge after `start` is accepted. Every command ends with the target in Run-Test/Idle.
- op 00:
  - TMS = 1,1,1,1,1,0.
  - 6 edges.
- op 01:
  - TMS = 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR).
  - Then IR_LEN shift edges, with TMS=0 on every shift edge except the last, which has TMS=1 (Exit1-IR).
  - Then TMS = 1,0 (Update-IR, Idle).
  - 4+IR_LEN+2 edges.
- op 10, len≥1:
  - TMS = 1,0,0.
  - Then len shift edges, with TMS=1 on the last.
  - Then TMS = 1,0.
  - len+5 edges.
- op 10, len=0:
  - TMS = 1,0,1,1,0 (Capture-DR to Exit1-DR directly).
  - 5 edges; `dout`=0.
- op 11:
  - len edges of TMS=0.
  - len=0 completes with zero target edges: `done` occurs one cycle after acceptance.
- len > DR_MAX is clamped to DR_MAX.

Data rules:
- `TDI` carries bit i of the latched data on shift edge i. It is 0 on all non-shift edges.
- `dout[i]` samples `TDO_in` on shift edge i.
- Completion: `done`=1 for exactly one cycle after the last edge. `busy` deasserts in the same cycle. `dout` holds its value until the next accepted `start`.
- The host never leaves the target in a Shift state between commands.

## Timing
- The FSM and TDO sampling run on the TCK rising edge.
- `TMS` and `TDI` are launched from registers clocked on the TCK falling edge. The target therefore samples them half a cycle after launch, with no hold race against the shared TCK.
- `start` is accepted at rising edge 0. The first TMS value is launched at the following falling edge and seen by the target at edge 1.
- Latency from acceptance to `done`:
  - reset: 6 cycles.
  - IR scan: IR_LEN+6 cycles.
  - DR scan: len+5 cycles.
  - idle: max(len,1) cycles.
- Back-to-back: a `start` in the `done` cycle is accepted, and edge 1 of the new command follows immediately.
- `TRST` mid-command aborts immediately. All outputs return to their reset values (`TMS`=1), and no `done` is produced. The caller must then issue op 00.

## Configuration
- `JTAG_HOST_TDO_RETIME_EN`: when defined, `dout[i]` samples `TDO_in` one rising edge later than shift edge i. This compensates for a target whose TDO passes through an extra TCK-clocked output flop. The final bit is taken on the Exit1 to Update edge, and edge counts are unchanged.
- When the macro is undefined, TDO is sampled on shift edge i as per the standard.

## Test plan
- `TRST` pulse, then op 00 → TMS = 1,1,1,1,1,0 on edges 1–6; `done` at cycle 6; target TAP state = Run-Test/Idle.
- op 01, `din`=2'b10, IR_LEN=2 → TMS = 1,1,0,0,0,1,1,0; TDI = 0 on shift edge 0 and 1 on shift edge 1; target `inst`=2'b10 (bypass); `done` at cycle 8.
- Bypass selected, op 10, len=8, `din`=8'hA5 → `dout`=8'h4A (1-bit bypass delay, first bit 0); `done` at cycle 13. With `JTAG_HOST_TDO_RETIME_EN` defined, the bench retimes TDO and the expected `dout` matches.
- op 11, len=3, with `start` held high throughout → 3 edges of TMS=0; a second command is accepted only in the `done` cycle.
- `TRST` asserted at shift edge 4 of a len=16 DR scan → `busy`=0, `TMS`=1, `dout`=0, no `done`.
- op 10, len=0 → TMS = 1,0,1,1,0; `done` at cycle 5; `dout`=0.
